axi_dma_mst: RTL

//  AXI4 master (initiator) that copies a block of 64-bit words from a source to a destination address.

---
 rtl/types_amba_pkg.sv | 62 ++++++
 rtl/axi_dma_buf.sv | 60 ++++++
 rtl/axi_dma_mst.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/types_amba_pkg.sv
// Shared AXI4 types and constants for the DMA master: bus widths, channel structs,
// burst/response encodings and the DMA FSM state enum.
package types_amba_pkg;

    localparam int CFG_SYSBUS_ADDR_BITS = 32;
    localparam int CFG_SYSBUS_DATA_BITS = 64;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B      = 3'd3;
    localparam int         AXI_RESP_ERR_BIT = 1;
    localparam int         AXI_4KB_BYTES    = 4096;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_DONE = 3'd6
    } dma_state_e;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [7:0]                      len;
        logic [2:0]                      size;
        logic [1:0]                      burst;
        logic [3:0]                      id;
        logic [3:0]                      cache;
        logic [2:0]                      prot;
    } axi4_a_chan_t;

    typedef struct packed {
        logic                              aw_valid;
        axi4_a_chan_t                      aw;
        logic                              w_valid;
        logic [CFG_SYSBUS_DATA_BITS-1:0]   w_data;
        logic [CFG_SYSBUS_DATA_BITS/8-1:0] w_strb;
        logic                              w_last;
        logic                              b_ready;
        logic                              ar_valid;
        axi4_a_chan_t                      ar;
        logic                              r_ready;
    } axi4_master_out_type;

    typedef struct packed {
        logic                            aw_ready;
        logic                            w_ready;
        logic                            b_valid;
        logic [1:0]                      b_resp;
        logic                            ar_ready;
        logic                            r_valid;
        logic [1:0]                      r_resp;
        logic [CFG_SYSBUS_DATA_BITS-1:0] r_data;
        logic                            r_last;
    } axi4_master_in_type;

    function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_dma_buf.sv
// Burst staging buffer for the DMA master: register array with independent
// write (read-data capture) and read (write-data issue) pointers, both cleared together.
module axi_dma_buf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    // Next-state for storage and pointers
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (i_wr_en) begin
                mem_d[wr_ptr_q] = i_wr_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (i_rd_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Storage and pointer registers
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign o_rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/axi_dma_mst.sv
// AXI4 DMA master: copies i_len 64-bit beats from src to dst with INCR read bursts
// then matching write bursts. Optional macro AXI_DMA_MST_ERR_ABORT_EN stops on error.
module axi_dma_mst
    import types_amba_pkg::*;
#(
    parameter bit async_reset = 1'b1,
    parameter int max_burst   = 16
) (
    input  logic                            i_clk,
    input  logic                            i_nrst,
    input  logic                            i_start,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0] i_src_addr,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0] i_dst_addr,
    input  logic [15:0]                     i_len,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err,
    input  axi4_master_in_type              i_xmsti,
    output axi4_master_out_type             o_xmsto
);
    localparam int ADDR_W = CFG_SYSBUS_ADDR_BITS;
    localparam int BW     = $clog2(max_burst) + 1;
`ifdef AXI_DMA_MST_ERR_ABORT_EN
    localparam bit ERR_ABORT = 1'b1;
`else
    localparam bit ERR_ABORT = 1'b0;
`endif

    dma_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  src_q, src_d, dst_q, dst_d;
    logic [15:0]        rem_q, rem_d;
    logic [BW-1:0]      blen_q, blen_d, beat_q, beat_d;
    logic               err_q, err_d, done_q, done_d;
    logic [BW-1:0]      blen_s;
    logic [16:0]        src_room_s, dst_room_s, blen_full_s;
    logic               last_beat_s;
    logic               buf_clr_s, buf_wr_s, buf_rd_s;
    logic [CFG_SYSBUS_DATA_BITS-1:0] buf_rd_data_s;
    logic               unused_s;

    // Burst length: remaining, max_burst and the beats left before either 4KB boundary
    always_comb begin
        src_room_s  = 17'(AXI_4KB_BYTES / 8) - {8'd0, src_q[11:3]};
        dst_room_s  = 17'(AXI_4KB_BYTES / 8) - {8'd0, dst_q[11:3]};
        blen_full_s = min17(min17({1'b0, rem_q}, 17'(max_burst)), min17(src_room_s, dst_room_s));
        blen_s      = blen_full_s[BW-1:0];
    end

    assign last_beat_s = (beat_q == blen_q - BW'(1));

    // FSM next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        blen_d    = blen_q;
        beat_d    = beat_q;
        err_d     = err_q;
        done_d    = (state_q == ST_DONE);
        buf_clr_s = 1'b0;
        buf_wr_s  = 1'b0;
        buf_rd_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    src_d   = {i_src_addr[ADDR_W-1:3], 3'b000};
                    dst_d   = {i_dst_addr[ADDR_W-1:3], 3'b000};
                    rem_d   = i_len;
                    err_d   = 1'b0;
                    state_d = (i_len == 16'd0) ? ST_DONE : ST_AR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                buf_clr_s = 1'b1;
                beat_d    = '0;
                if (i_xmsti.ar_ready) begin
                    blen_d  = blen_s;
                    state_d = ST_R;
                end else begin
                    state_d = ST_AR;
                end
            end
            ST_R: begin
                if (i_xmsti.r_valid) begin
                    buf_wr_s = 1'b1;
                    beat_d   = beat_q + BW'(1);
                    // The beat count ends the burst; r_last disagreeing with it is an error
                    err_d    = err_q | i_xmsti.r_resp[AXI_RESP_ERR_BIT]
                             | (i_xmsti.r_last != last_beat_s);
                    if (last_beat_s) begin
                        state_d = (ERR_ABORT && err_d) ? ST_DONE : ST_AW;
                    end else begin
                        state_d = ST_R;
                    end
                end else begin
                    state_d = ST_R;
                end
            end
            ST_AW: begin
                beat_d = '0;
                if (i_xmsti.aw_ready) begin
                    state_d = ST_W;
                end else begin
                    state_d = ST_AW;
                end
            end
            ST_W: begin
                if (i_xmsti.w_ready) begin
                    buf_rd_s = 1'b1;
                    beat_d   = beat_q + BW'(1);
                    state_d  = last_beat_s ? ST_B : ST_W;
                end else begin
                    state_d = ST_W;
                end
            end
            ST_B: begin
                if (i_xmsti.b_valid) begin
                    err_d = err_q | i_xmsti.b_resp[AXI_RESP_ERR_BIT];
                    src_d = src_q + ADDR_W'({blen_q, 3'b000});
                    dst_d = dst_q + ADDR_W'({blen_q, 3'b000});
                    rem_d = rem_q - 16'(blen_q);
                    if ((rem_d == 16'd0) || (ERR_ABORT && err_d)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_AR;
                    end
                end else begin
                    state_d = ST_B;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            blen_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            blen_q  <= blen_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Bus outputs decoded from registered state only
    always_comb begin
        o_xmsto          = '0;
        o_xmsto.ar.size  = AXI_SIZE_8B;
        o_xmsto.ar.burst = AXI_BURST_INCR;
        o_xmsto.ar.addr  = src_q;
        o_xmsto.ar.len   = 8'(blen_s - BW'(1));
        o_xmsto.ar_valid = (state_q == ST_AR);
        o_xmsto.r_ready  = (state_q == ST_R);
        o_xmsto.aw.size  = AXI_SIZE_8B;
        o_xmsto.aw.burst = AXI_BURST_INCR;
        o_xmsto.aw.addr  = dst_q;
        o_xmsto.aw.len   = 8'(blen_q - BW'(1));
        o_xmsto.aw_valid = (state_q == ST_AW);
        o_xmsto.w_valid  = (state_q == ST_W);
        o_xmsto.w_data   = buf_rd_data_s;
        o_xmsto.w_strb   = 8'hFF;
        o_xmsto.w_last   = (state_q == ST_W) && last_beat_s;
        o_xmsto.b_ready  = (state_q == ST_B);
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;
    assign o_err  = err_q;

    axi_dma_buf #(
        .DEPTH(max_burst),
        .WIDTH(CFG_SYSBUS_DATA_BITS)
    ) u_buf (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_clr    (buf_clr_s),
        .i_wr_en  (buf_wr_s),
        .i_wr_data(i_xmsti.r_data),
        .i_rd_en  (buf_rd_s),
        .o_rd_data(buf_rd_data_s)
    );

    assign unused_s = ^{async_reset, i_src_addr[2:0], i_dst_addr[2:0],
                        i_xmsti.r_resp[0], i_xmsti.b_resp[0], blen_full_s[16:BW]};

endmodule
